// File: rtl/warmboot_pkg.sv
// Shared types and constants for the warmboot sequencer and its timer.
// Pure declarations: no latency and no flow control.
package warmboot_pkg;

    typedef enum logic [2:0] {
        LOCKWAIT = 3'd0,
        RUN      = 3'd1,
        DETACH   = 3'd2,
        SETUP    = 3'd3,
        FIRE     = 3'd4,
        HALT     = 3'd5
    } wb_state_t;

    typedef logic [1:0] image_t;

    localparam int MAX_IMAGES = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Saturating up-counter with combinational done flag (count == limit).
// The flag is valid in the same cycle as count; clear takes priority over enable.
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             done
);

    logic [WIDTH-1:0] count;

    assign done = (count == limit);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !done) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/warmboot_sequencer.sv
// Power-up and multi-image warmboot sequencer between the PLL/SB_WARMBOOT and the core.
// Boot fires 1+DETACH+SETUP+1 edges after an accepted request; once committed, inputs are ignored.
module warmboot_sequencer
    import warmboot_pkg::*;
#(
    parameter int NUM_IMAGES         = 4,
    parameter int DEFAULT_IMAGE      = 1,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int DETACH_CYCLES      = 1200000,
    parameter int SETUP_CYCLES       = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_lock,
    input  logic       boot_req,
    input  logic [1:0] boot_image,
    output logic       boot_ack,
    output logic       boot_err,
    output logic       busy,
    output logic       core_reset,
    output logic       usb_pu,
    output logic       usb_tx_inhibit,
    output logic [1:0] wb_s,
    output logic       wb_boot
);

    localparam int CNT_W = $clog2(max_int(LOCK_STABLE_CYCLES, DETACH_CYCLES) + 1);
    localparam int NIMG  = (NUM_IMAGES > MAX_IMAGES) ? MAX_IMAGES : NUM_IMAGES;
    localparam image_t DEF_IMG = image_t'(DEFAULT_IMAGE);

    // The timer starts at 0 on state entry, so a state lasting N cycles terminates at N-1.
    localparam logic [CNT_W-1:0] LOCK_LIM   = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DETACH_LIM = CNT_W'(DETACH_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LIM  = CNT_W'(SETUP_CYCLES - 1);

    wb_state_t        state;
    logic             t_done;
    logic             t_clear;
    logic             t_enable;
    logic [CNT_W-1:0] t_limit;
    logic             img_ok;
    logic             state_exit;

    assign img_ok = (int'(boot_image) < NIMG);

    always_comb begin
        t_limit    = '0;
        t_enable   = 1'b0;
        state_exit = 1'b0;
        case (state)
            LOCKWAIT: begin
                t_limit    = LOCK_LIM;
                t_enable   = pll_lock;
                state_exit = pll_lock && t_done;
            end
            RUN:    state_exit = !pll_lock || (boot_req && img_ok);
            DETACH: begin
                t_limit    = DETACH_LIM;
                t_enable   = 1'b1;
                state_exit = t_done;
            end
            SETUP: begin
                t_limit    = SETUP_LIM;
                t_enable   = 1'b1;
                state_exit = t_done;
            end
            FIRE:    state_exit = 1'b1;
            default: state_exit = 1'b0;
        endcase
    end

    // A lock dropout during qualification restarts the stability count.
    assign t_clear = state_exit || (state == LOCKWAIT && !pll_lock);

    cycle_timer #(.WIDTH(CNT_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (t_clear),
        .enable  (t_enable),
        .limit   (t_limit),
        .done    (t_done)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= LOCKWAIT;
            core_reset     <= 1'b1;
            usb_pu         <= 1'b0;
            usb_tx_inhibit <= 1'b1;
            wb_s           <= DEF_IMG;
            wb_boot        <= 1'b0;
            boot_ack       <= 1'b0;
            boot_err       <= 1'b0;
            busy           <= 1'b1;
        end else begin
            boot_ack <= 1'b0;
            boot_err <= 1'b0;
            case (state)
                LOCKWAIT: begin
                    if (pll_lock && t_done) begin
                        state          <= RUN;
                        core_reset     <= 1'b0;
                        usb_pu         <= 1'b1;
                        usb_tx_inhibit <= 1'b0;
                        busy           <= 1'b0;
                    end
                end
                RUN: begin
                    if (!pll_lock) begin
                        state          <= LOCKWAIT;
                        core_reset     <= 1'b1;
                        usb_pu         <= 1'b0;
                        usb_tx_inhibit <= 1'b1;
                        wb_s           <= DEF_IMG;
                        busy           <= 1'b1;
                    end else if (boot_req && img_ok) begin
                        state          <= DETACH;
                        wb_s           <= boot_image;
                        boot_ack       <= 1'b1;
                        usb_pu         <= 1'b0;
                        usb_tx_inhibit <= 1'b1;
                        busy           <= 1'b1;
                    end else if (boot_req) begin
                        boot_err <= 1'b1;
                    end
                end
                DETACH: if (t_done) state <= SETUP;
                SETUP:  if (t_done) state <= FIRE;
                FIRE: begin
                    wb_boot <= 1'b1;
                    state   <= HALT;
                end
                HALT:    state <= HALT;
                default: state <= LOCKWAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Directed bench for warmboot_sequencer with short timing parameters and hand-derived edge counts.
module tb_warmboot_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_lock;
    logic       boot_req;
    logic [1:0] boot_image;
    logic       boot_ack;
    logic       boot_err;
    logic       busy;
    logic       core_reset;
    logic       usb_pu;
    logic       usb_tx_inhibit;
    logic [1:0] wb_s;
    logic       wb_boot;

    int tests  = 0;
    int failed = 0;

    warmboot_sequencer #(
        .NUM_IMAGES         (3),
        .DEFAULT_IMAGE      (1),
        .LOCK_STABLE_CYCLES (8),
        .DETACH_CYCLES      (20),
        .SETUP_CYCLES       (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pll_lock       (pll_lock),
        .boot_req       (boot_req),
        .boot_image     (boot_image),
        .boot_ack       (boot_ack),
        .boot_err       (boot_err),
        .busy           (busy),
        .core_reset     (core_reset),
        .usb_pu         (usb_pu),
        .usb_tx_inhibit (usb_tx_inhibit),
        .wb_s           (wb_s),
        .wb_boot        (wb_boot)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " core_reset"}, 32'(core_reset), 32'd1);
        check({tag, " usb_pu"}, 32'(usb_pu), 32'd0);
        check({tag, " usb_tx_inhibit"}, 32'(usb_tx_inhibit), 32'd1);
        check({tag, " wb_s"}, 32'(wb_s), 32'd1);
        check({tag, " wb_boot"}, 32'(wb_boot), 32'd0);
        check({tag, " ack/err"}, {30'd0, boot_ack, boot_err}, 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd1);
    endtask

    initial begin
        reset_n    = 1'b0;
        pll_lock   = 1'b0;
        boot_req   = 1'b0;
        boot_image = 2'd0;
        tick(3);
        check_reset_vals("reset");

        // Power-up with a one-cycle lock glitch after four good cycles
        reset_n  = 1'b1;
        pll_lock = 1'b1;
        tick(4);
        check("pre_glitch core_reset", 32'(core_reset), 32'd1);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(7);
        check("lock 7 core_reset", 32'(core_reset), 32'd1);
        check("lock 7 usb_pu", 32'(usb_pu), 32'd0);
        tick(1);
        check("lock 8 core_reset", 32'(core_reset), 32'd0);
        check("lock 8 usb_pu", 32'(usb_pu), 32'd1);
        check("lock 8 tx_inhibit", 32'(usb_tx_inhibit), 32'd0);
        check("lock 8 busy", 32'(busy), 32'd0);

        // Out-of-range index
        boot_req   = 1'b1;
        boot_image = 2'd3;
        tick(1);
        boot_req = 1'b0;
        check("bad_idx err", 32'(boot_err), 32'd1);
        check("bad_idx ack", 32'(boot_ack), 32'd0);
        check("bad_idx busy", 32'(busy), 32'd0);
        check("bad_idx wb_s", 32'(wb_s), 32'd1);
        tick(1);
        check("bad_idx err pulse", 32'(boot_err), 32'd0);

        // Lock loss in RUN with a simultaneous valid request
        pll_lock   = 1'b0;
        boot_req   = 1'b1;
        boot_image = 2'd2;
        tick(1);
        check("lockloss ack", 32'(boot_ack), 32'd0);
        check("lockloss core_reset", 32'(core_reset), 32'd1);
        check("lockloss usb_pu", 32'(usb_pu), 32'd0);
        check("lockloss busy", 32'(busy), 32'd1);
        check("lockloss wb_s", 32'(wb_s), 32'd1);
        pll_lock = 1'b1;
        tick(1);
        check("lockwait req ack/err", {30'd0, boot_ack, boot_err}, 32'd0);
        boot_req = 1'b0;
        tick(6);
        check("relock 7 core_reset", 32'(core_reset), 32'd1);
        tick(1);
        check("relock 8 core_reset", 32'(core_reset), 32'd0);

        // Valid boot; lock loss and a foreign request during DETACH are ignored
        boot_req   = 1'b1;
        boot_image = 2'd2;
        tick(1);
        boot_req = 1'b0;
        check("boot ack", 32'(boot_ack), 32'd1);
        check("boot wb_s", 32'(wb_s), 32'd2);
        check("boot usb_pu", 32'(usb_pu), 32'd0);
        check("boot tx_inhibit", 32'(usb_tx_inhibit), 32'd1);
        check("boot busy", 32'(busy), 32'd1);
        check("boot core_reset", 32'(core_reset), 32'd0);
        tick(1);
        check("boot ack pulse", 32'(boot_ack), 32'd0);
        pll_lock   = 1'b0;
        boot_req   = 1'b1;
        boot_image = 2'd0;
        tick(1);
        boot_req = 1'b0;
        check("detach req ack/err", {30'd0, boot_ack, boot_err}, 32'd0);
        check("detach req wb_s", 32'(wb_s), 32'd2);
        check("detach lockloss core_reset", 32'(core_reset), 32'd0);
        tick(20);
        check("edge23 wb_boot", 32'(wb_boot), 32'd0);
        check("edge23 wb_s", 32'(wb_s), 32'd2);
        tick(1);
        check("edge24 wb_boot", 32'(wb_boot), 32'd1);
        tick(5);
        check("halt wb_boot", 32'(wb_boot), 32'd1);
        check("halt wb_s", 32'(wb_s), 32'd2);
        check("halt usb_pu", 32'(usb_pu), 32'd0);
        check("halt busy", 32'(busy), 32'd1);
        check("halt core_reset", 32'(core_reset), 32'd0);

        // Reset from HALT
        reset_n = 1'b0;
        tick(1);
        check_reset_vals("halt_rst");

        // Reset during SETUP
        reset_n  = 1'b1;
        pll_lock = 1'b1;
        tick(8);
        check("restart core_reset", 32'(core_reset), 32'd0);
        boot_req   = 1'b1;
        boot_image = 2'd0;
        tick(1);
        boot_req = 1'b0;
        check("boot0 ack", 32'(boot_ack), 32'd1);
        check("boot0 wb_s", 32'(wb_s), 32'd0);
        tick(20);
        reset_n = 1'b0;
        tick(1);
        check_reset_vals("setup_rst");
        reset_n = 1'b1;
        tick(7);
        check("post_rst 7 core_reset", 32'(core_reset), 32'd1);
        tick(1);
        check("post_rst 8 core_reset", 32'(core_reset), 32'd0);
        check("post_rst 8 wb_boot", 32'(wb_boot), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/warmboot_sequencer.md
Name: warmboot_sequencer

Overview:
- Parametrised successor to the fixed single-image warmboot hookup. Sequences power-up (PLL lock qualification, core reset release, USB pull-up enable) and a runtime-selectable multi-image warmboot.
- Warmboot path: latch the image index, detach from USB for a programmable time, hold the image-select lines stable, then fire SB_WARMBOOT BOOT.
- Sits in the board top between the PLL/SB_WARMBOOT primitives and the bootloader core.

Parameters:
- NUM_IMAGES, 4, number of selectable images. Legal range 2..4.
- DEFAULT_IMAGE, 1, value driven on wb_s from reset until a request is accepted. Must be less than NUM_IMAGES.
- LOCK_STABLE_CYCLES, 1024, consecutive clk cycles pll_lock must stay high before the core is released.
- DETACH_CYCLES, 1200000, clk cycles with pull-up removed before boot (100 ms at 12 MHz).
- SETUP_CYCLES, 2, clk cycles wb_s is held stable before wb_boot rises.
- CNT_W, derived as clog2(max(LOCK_STABLE_CYCLES, DETACH_CYCLES)+1), timer width. Not to be overridden.

Ports:
- clk  in  1  sequencer clock (12 MHz domain).
- reset_n  in  1  synchronous, active-low reset.
- pll_lock  in  1  PLL LOCK, already synchronised to clk.
- boot_req  in  1  single-cycle request from core.
- boot_image  in  2  image index, sampled with boot_req.
- boot_ack  out  1  one-cycle pulse when a request is accepted.
- boot_err  out  1  one-cycle pulse when a request is rejected (index out of range).
- busy  out  1  high in every state except RUN.
- core_reset  out  1  active-high reset to the bootloader core.
- usb_pu  out  1  USB pull-up enable.
- usb_tx_inhibit  out  1  forces the USB tristate enable low.
- wb_s  out  2  SB_WARMBOOT {S1,S0}.
- wb_boot  out  1  SB_WARMBOOT BOOT.

Behaviour:
- Single clock domain. Every register is reset only when reset_n is low at a rising edge of clk.
- All outputs are registered.
- Reset values:
  - state=LOCKWAIT, timer=0.
  - core_reset=1, usb_pu=0, usb_tx_inhibit=1.
  - wb_s=DEFAULT_IMAGE, wb_boot=0.
  - boot_ack=0, boot_err=0, busy=1.
- LOCKWAIT:
  - The timer counts cycles with pll_lock=1. Any cycle with pll_lock=0 clears it.
  - When the count reaches LOCK_STABLE_CYCLES, go to RUN on the next edge.
  - On entry to RUN: core_reset=0, usb_pu=1, usb_tx_inhibit=0, busy=0.
- RUN:
  - If pll_lock=0, return to LOCKWAIT on the next edge with the reset output values. Any boot_req in that cycle is ignored.
  - Otherwise, boot_req=1 with boot_image<NUM_IMAGES: latch the index to wb_s, pulse boot_ack, go to DETACH.
  - Otherwise, boot_req=1 with boot_image>=NUM_IMAGES: pulse boot_err, stay in RUN, wb_s unchanged.
- DETACH:
  - usb_pu=0, usb_tx_inhibit=1, busy=1. core_reset stays 0.
  - Stay for exactly DETACH_CYCLES cycles, then go to SETUP.
- SETUP: wb_s held. Stay for SETUP_CYCLES cycles, then go to FIRE.
- FIRE: wb_boot=1. Go to HALT on the next edge.
- HALT:
  - wb_boot stays 1 and all other outputs are frozen.
  - Only reset_n exits this state (the device reconfigures first in practice).
- Commitment: once DETACH is entered, pll_lock, boot_req and boot_image are ignored and the sequence always completes.
- boot_req outside RUN: no ack, no err.
- wb_s never changes in DETACH, SETUP, FIRE or HALT.
- Latency from accepted boot_req to wb_boot rising = 1 + DETACH_CYCLES + SETUP_CYCLES + 1 clk edges.
- Reset mid-operation, including in FIRE or HALT: immediate return to the reset values on that edge (wb_boot drops to 0).
- Timer: CNT_W-bit counter, cleared on every state change, with no wrap-around. Its terminal compare is equality with the state's limit.

Decomposition:
- Shared package warmboot_pkg:
  - State encoding as a 3-bit enum: LOCKWAIT, RUN, DETACH, SETUP, FIRE, HALT.
  - Image index type (2 bits).
  - Constant MAX_IMAGES=4.
- One sub-module, cycle_timer:
  - Parameter WIDTH.
  - Inputs: clear, enable, limit.
  - Output: done, asserted combinationally when count==limit.
  - Count saturates at limit.
- The top sequencer holds the FSM and the output registers.

Test Plan:
(All cases use LOCK_STABLE_CYCLES=8, DETACH_CYCLES=20, SETUP_CYCLES=2, NUM_IMAGES=3.)
- Power-up: release reset_n, pll_lock high, glitch low at cycle 5 then high again -> core_reset and usb_pu change only 8 cycles after the glitch ends. core_reset goes 1->0 and usb_pu goes 0->1 on the same edge.
- Valid boot: in RUN, boot_req with boot_image=2 -> boot_ack pulse on the next edge and wb_s=2'b10. usb_pu=0 for exactly 20 cycles, then 2 SETUP cycles. wb_boot rises 24 edges after the request and stays high.
- Invalid index: boot_req with boot_image=3 -> boot_err pulse, no boot_ack, state stays RUN, wb_s=DEFAULT_IMAGE(1).
- Lock loss: pll_lock drops in RUN -> next edge core_reset=1, usb_pu=0, busy=1. A boot_req in that same cycle produces no ack. A later lock loss in DETACH does not stop the sequence.
- Reset mid-sequence: assert reset_n low during SETUP -> the next edge shows all reset values (wb_boot=0, wb_s=1). Releasing reset_n restarts at LOCKWAIT.
- Ignored request: boot_req pulses while in DETACH with a different index -> no ack, no err, wb_s unchanged through HALT.
